// File: rtl/spaceinvaders_pkg.sv
// Shared Space Invaders constants: enemy grid size, index width and the fire scheduler state encoding.
package spaceinvaders_pkg;

    localparam int LINHAS  = 5;
    localparam int COLUNAS = 13;
    localparam int IDX_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIRE = 2'd2
    } fire_state_t;

    // Column index increment with wrap from n-1 back to 0.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v, input int n);
        return (int'(v) == n - 1) ? '0 : v + IDX_W'(1);
    endfunction

endpackage

// File: rtl/enemy_col_bottom.sv
// Combinational bottom-most alive enemy finder for one column (bit k = row k, row 0 = top).
module enemy_col_bottom
    import spaceinvaders_pkg::*;
#(
    parameter int ROWS = spaceinvaders_pkg::LINHAS
) (
    input  logic [ROWS-1:0]  col_bits,
    output logic             found,
    output logic [IDX_W-1:0] row
);

    // Later (higher) rows overwrite earlier ones, so the last hit is the bottom-most.
    always_comb begin
        found = 1'b0;
        row   = '0;
        for (int k = 0; k < ROWS; k++) begin
            if (col_bits[k]) begin
                found = 1'b1;
                row   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Enemy fire scheduler: periodic column scan picking the bottom-most alive shooter.
// Define FIRE_RANDOM_EN to seed each scan start column from an 8-bit LFSR.
module enemy_fire_scheduler
    import spaceinvaders_pkg::*;
#(
    parameter int LINHAS      = spaceinvaders_pkg::LINHAS,
    parameter int COLUNAS     = spaceinvaders_pkg::COLUNAS,
    parameter int FIRE_PERIOD = 10000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      game_active,
    input  logic [LINHAS*COLUNAS-1:0] enemy_alive,
    input  logic                      shot_busy,
    input  logic                      fire_ack,
    output logic                      fire_req,
    output logic [IDX_W-1:0]          fire_col,
    output logic [IDX_W-1:0]          fire_row,
    output logic                      no_target
);

    localparam int               TMR_W      = $clog2(FIRE_PERIOD);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(FIRE_PERIOD - 1);
    localparam int               AW         = LINHAS * COLUNAS;
    localparam int               TGT_W      = $clog2(AW);

    fire_state_t      state_reg, state_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [IDX_W-1:0] scan_cnt_reg, scan_cnt_next;
    logic [IDX_W-1:0] fire_col_reg, fire_col_next;
    logic [IDX_W-1:0] fire_row_reg, fire_row_next;
    logic             no_target_reg, no_target_next;

    logic [LINHAS-1:0] col_bits;
    logic              col_found;
    logic [IDX_W-1:0]  col_row;
    logic [TGT_W-1:0]  tgt_idx;
    logic              tgt_alive;

    for (genvar gi = 0; gi < LINHAS; gi++) begin : g_col_bits
        assign col_bits[gi] = enemy_alive[TGT_W'(gi * COLUNAS) + TGT_W'(ptr_reg)];
    end

    enemy_col_bottom #(.ROWS(LINHAS)) u_col_bottom (
        .col_bits (col_bits),
        .found    (col_found),
        .row      (col_row)
    );

    assign tgt_idx   = TGT_W'(fire_row_reg) * TGT_W'(COLUNAS) + TGT_W'(fire_col_reg);
    assign tgt_alive = enemy_alive[tgt_idx];

`ifdef FIRE_RANDOM_EN
    logic [7:0] lfsr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg <= 8'hA5;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            timer_reg     <= TMR_RELOAD;
            ptr_reg       <= '0;
            scan_cnt_reg  <= '0;
            fire_col_reg  <= '0;
            fire_row_reg  <= '0;
            no_target_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            ptr_reg       <= ptr_next;
            scan_cnt_reg  <= scan_cnt_next;
            fire_col_reg  <= fire_col_next;
            fire_row_reg  <= fire_row_next;
            no_target_reg <= no_target_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        ptr_next       = ptr_reg;
        scan_cnt_next  = scan_cnt_reg;
        fire_col_next  = fire_col_reg;
        fire_row_next  = fire_row_reg;
        no_target_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (timer_reg != '0) begin
                    timer_next = timer_reg - TMR_W'(1);
                end else if (!shot_busy) begin
                    state_next    = ST_SCAN;
                    scan_cnt_next = '0;
`ifdef FIRE_RANDOM_EN
                    ptr_next      = IDX_W'(lfsr_reg % 8'(COLUNAS));
`endif
                end
            end
            ST_SCAN: begin
                if (col_found) begin
                    fire_col_next = ptr_reg;
                    fire_row_next = col_row;
                    state_next    = ST_FIRE;
                end else begin
                    ptr_next = wrap_inc(ptr_reg, COLUNAS);
                    if (scan_cnt_reg == IDX_W'(COLUNAS - 1)) begin
                        no_target_next = 1'b1;
                        timer_next     = TMR_RELOAD;
                        state_next     = ST_IDLE;
                    end else begin
                        scan_cnt_next = scan_cnt_reg + IDX_W'(1);
                    end
                end
            end
            ST_FIRE: begin
                // Ack wins over a simultaneous target death.
                if (fire_ack) begin
                    ptr_next   = wrap_inc(fire_col_reg, COLUNAS);
                    timer_next = TMR_RELOAD;
                    state_next = ST_IDLE;
                end else if (!tgt_alive) begin
                    ptr_next      = fire_col_reg;
                    scan_cnt_next = '0;
                    state_next    = ST_SCAN;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (!game_active) begin
            state_next     = ST_IDLE;
            timer_next     = TMR_RELOAD;
            ptr_next       = ptr_reg;
            scan_cnt_next  = scan_cnt_reg;
            fire_col_next  = fire_col_reg;
            fire_row_next  = fire_row_reg;
            no_target_next = 1'b0;
        end
    end

    always_comb begin
        fire_req  = (state_reg == ST_FIRE);
        fire_col  = fire_col_reg;
        fire_row  = fire_row_reg;
        no_target = no_target_reg;
    end

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Self-checking bench for enemy_fire_scheduler: directed scenarios plus randomized traffic vs a reference model.
module tb_enemy_fire_scheduler;

    localparam int LIN = 5;
    localparam int COL = 13;
    localparam int PER = 4;
    localparam int AW  = LIN * COL;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          game_active = 1'b0;
    logic [AW-1:0] enemy_alive = '0;
    logic          shot_busy = 1'b0;
    logic          fire_ack = 1'b0;
    logic          fire_req;
    logic [5:0]    fire_col;
    logic [5:0]    fire_row;
    logic          no_target;

    int checks = 0;
    int errors = 0;

    // Reference model state: mode 0 = idle, 1 = scan, 2 = fire.
    int m_mode, m_timer, m_ptr, m_col, m_row, m_empties;
    bit m_notgt;
`ifdef FIRE_RANDOM_EN
    logic [7:0] m_lfsr;
`endif

    always #5 clk = ~clk;

    enemy_fire_scheduler #(.LINHAS(LIN), .COLUNAS(COL), .FIRE_PERIOD(PER)) dut (
        .clk         (clk),
        .reset       (reset),
        .game_active (game_active),
        .enemy_alive (enemy_alive),
        .shot_busy   (shot_busy),
        .fire_ack    (fire_ack),
        .fire_req    (fire_req),
        .fire_col    (fire_col),
        .fire_row    (fire_row),
        .no_target   (no_target)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int bottom_row(input int c);
        int r = -1;
        for (int k = 0; k < LIN; k++) begin
            if (enemy_alive[k * COL + c]) r = k;
        end
        return r;
    endfunction

    task automatic model_edge();
        int r;
        if (reset) begin
            m_mode = 0; m_timer = PER - 1; m_ptr = 0; m_col = 0; m_row = 0;
            m_empties = 0; m_notgt = 0;
`ifdef FIRE_RANDOM_EN
            m_lfsr = 8'hA5;
`endif
            return;
        end
        m_notgt = 0;
        if (!game_active) begin
            m_mode = 0;
            m_timer = PER - 1;
        end else if (m_mode == 0) begin
            if (m_timer > 0) m_timer--;
            else if (!shot_busy) begin
                m_mode = 1;
                m_empties = 0;
`ifdef FIRE_RANDOM_EN
                m_ptr = int'(m_lfsr) % COL;
`endif
            end
        end else if (m_mode == 1) begin
            r = bottom_row(m_ptr);
            if (r >= 0) begin
                m_col = m_ptr; m_row = r; m_mode = 2;
            end else begin
                m_ptr = (m_ptr + 1) % COL;
                m_empties++;
                if (m_empties == COL) begin
                    m_notgt = 1; m_timer = PER - 1; m_mode = 0;
                end
            end
        end else begin
            if (fire_ack) begin
                m_ptr = (m_col + 1) % COL; m_timer = PER - 1; m_mode = 0;
            end else if (!enemy_alive[m_row * COL + m_col]) begin
                m_ptr = m_col; m_empties = 0; m_mode = 1;
            end
        end
`ifdef FIRE_RANDOM_EN
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("req", fire_req, (m_mode == 2));
        check("col", fire_col, m_col);
        check("row", fire_row, m_row);
        check("notgt", no_target, m_notgt);
    endtask

    task automatic reset_dut();
        reset = 1'b1; game_active = 1'b1; shot_busy = 1'b0; fire_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_fire(input int budget, output int n);
        n = 0;
        while (!fire_req && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic ack_once();
        fire_ack = 1'b1;
        tick();
        fire_ack = 1'b0;
        check("ack_drop", fire_req, 0);
    endtask

    initial begin
        int n, pulses, first_pulse, req_hi, saved_col;

        // Reset state and first shot with every enemy alive.
        enemy_alive = '1;
        reset_dut();
        check("rst_req", fire_req, 0);
        check("rst_col", fire_col, 0);
        check("rst_row", fire_row, 0);
        check("rst_notgt", no_target, 0);
        wait_fire(30, n);
        check("lat_first", n, 5);
`ifdef FIRE_RANDOM_EN
        check("lfsr_col", fire_col, 3);
`else
        check("first_col", fire_col, 0);
`endif
        check("first_row", fire_row, 4);
        ack_once();
        wait_fire(30, n);
        check("lat_second", n, 5);
`ifndef FIRE_RANDOM_EN
        check("second_col", fire_col, 1);
`endif

        // Target dies while ack is withheld: rescan same column, pick next row up.
        saved_col = m_col;
        enemy_alive[m_row * COL + m_col] = 1'b0;
        tick();
        check("die_drop", fire_req, 0);
        tick();
        check("die_refire", fire_req, 1);
        check("die_col", fire_col, saved_col);
        check("die_row", fire_row, 3);
        ack_once();

        // Single survivor in the last column.
        enemy_alive = '0;
        enemy_alive[2 * COL + 12] = 1'b1;
        reset_dut();
        wait_fire(40, n);
`ifndef FIRE_RANDOM_EN
        check("lone_lat", n, 17);
`endif
        check("lone_col", fire_col, 12);
        check("lone_row", fire_row, 2);
        ack_once();

        // Empty field: exactly one no_target pulse, never a request.
        enemy_alive = '0;
        reset_dut();
        pulses = 0; first_pulse = -1; req_hi = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (no_target) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
            end
            if (fire_req) req_hi++;
        end
        check("nt_pulses", pulses, 1);
        check("nt_when", first_pulse, 17);
        check("nt_req", req_hi, 0);

        // Shot in flight at expiry holds off the scan.
        enemy_alive = '1;
        reset_dut();
        shot_busy = 1'b1;
        req_hi = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (fire_req) req_hi++;
        end
        check("busy_req", req_hi, 0);
        shot_busy = 1'b0;
        tick();
        check("busy_scan", fire_req, 0);
        tick();
        check("busy_fire", fire_req, 1);

        // Game stop and reset while firing.
        game_active = 1'b0;
        tick();
        check("stop_drop", fire_req, 0);
        game_active = 1'b1;
        wait_fire(30, n);
        check("restart_lat", n, 5);
        reset = 1'b1;
        tick();
        check("rst_fire_drop", fire_req, 0);
        reset = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            game_active = ($urandom_range(0, 31) != 0);
            shot_busy   = ($urandom_range(0, 7) == 0);
            fire_ack    = ($urandom_range(0, 3) == 0);
            reset       = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 7) == 0)
                enemy_alive[$urandom_range(0, AW - 1)] = 1'b0;
            if ($urandom_range(0, 63) == 0) begin
                for (int b = 0; b < AW; b++) enemy_alive[b] = ($urandom_range(0, 5) == 0);
            end
            if ($urandom_range(0, 255) == 0) enemy_alive = '1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enemy_fire_scheduler.md
ENEMY_FIRE_SCHEDULER -- requirements
Module: enemy_fire_scheduler

Interface
REQ-001 Parameter LINHAS, default 5: number of enemy rows.
REQ-002 Parameter COLUNAS, default 13: number of enemy columns.
REQ-003 Parameter FIRE_PERIOD, default 10000000: clk cycles between fire attempts; must be at least 2.
REQ-004 clk  in  1  system clock. The block has one clock; reset is synchronous and active-high.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 game_active  in  1  high while the game is in the in-play state.
REQ-007 enemy_alive  in  LINHAS*COLUNAS  alive flags; bit index = row*COLUNAS+col; row 0 = top.
REQ-008 shot_busy  in  1  high while an enemy shot is in flight.
REQ-009 fire_ack  in  1  one-cycle acceptance of the shot by the enemy munition block.
REQ-010 fire_req  out  1  shot request; held high until acknowledged.
REQ-011 fire_col  out  6  column of the shooter.
REQ-012 fire_row  out  6  row of the shooter.
REQ-013 no_target  out  1  one-cycle pulse when a full scan finds no alive enemy.

Function
REQ-014 The block SHALL use a 3-state FSM: IDLE, SCAN, FIRE.
REQ-015 In IDLE with game_active=1, the period timer SHALL decrement once per cycle, stopping at 0.
REQ-016 IDLE->SCAN SHALL occur on the cycle after the timer reaches 0 and shot_busy=0; while shot_busy=1 the FSM SHALL stay in IDLE with the timer held at 0.
REQ-017 SCAN SHALL examine one column per cycle, starting at the column pointer.
REQ-018 For the examined column, the block SHALL select the bottom-most alive enemy: the highest row k with enemy_alive[k*COLUNAS+col]=1.
REQ-019 On a hit, the block SHALL latch fire_col/fire_row and enter FIRE on the next cycle; fire_req SHALL be high from that cycle.
REQ-020 On an empty column, the pointer SHALL advance; it SHALL wrap from COLUNAS-1 to 0.
REQ-021 After COLUNAS consecutive empty columns, the block SHALL pulse no_target, reload the timer to FIRE_PERIOD-1, and return to IDLE.
REQ-022 In FIRE, fire_req, fire_col and fire_row SHALL be stable until fire_ack=1.
REQ-023 On fire_ack, the block SHALL drop fire_req the next cycle, set pointer = fire_col+1 (wrapped), reload the timer, and go to IDLE.
REQ-024 If the latched target's alive bit drops in FIRE without fire_ack, the block SHALL drop fire_req and re-enter SCAN at the same column.
REQ-025 When fire_ack and target death occur in the same cycle, the ack SHALL take priority.
REQ-026 fire_ack outside FIRE SHALL be ignored.
REQ-027 game_active=0 in any state SHALL force IDLE next cycle with fire_req=0 and the timer reloaded; the pointer SHALL be kept.
REQ-028 Latency from timer expiry to fire_req, when the first scanned column is non-empty, SHALL be 2 cycles.

Reset
REQ-029 On reset, the block SHALL enter IDLE with fire_req=0, fire_col=0, fire_row=0, no_target=0, pointer=0 and timer=FIRE_PERIOD-1.
REQ-030 Reset SHALL override every other input, including reset asserted mid-SCAN or mid-FIRE.

Configuration
REQ-031 With FIRE_RANDOM_EN defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset; advances every clk) SHALL set the pointer to lfsr mod COLUNAS on each IDLE->SCAN transition.
REQ-032 Without FIRE_RANDOM_EN, the pointer SHALL be strict round-robin per REQ-020/REQ-023, and no LFSR logic SHALL exist.

Structure
REQ-033 LINHAS, COLUNAS, the FSM state encoding and the 6-bit index width SHALL live in the shared package spaceinvaders_pkg.
REQ-034 Bottom-most-alive selection for one column SHALL be a combinational sub-module, enemy_col_bottom (column bits in; found flag and row out).

Verification
REQ-035 Bench: FIRE_PERIOD=4, all alive, shot_busy=0 -> fire_req rises 2 cycles after timer expiry with col=0, row=4; ack -> the next shot uses col=1.
REQ-036 Bench: only enemy 2*13+12 alive, pointer=0 -> 13 SCAN cycles, then fire_col=12, fire_row=2.
REQ-037 Bench: all enemy_alive=0 -> no_target pulses once after 13 SCAN cycles, fire_req stays 0, FSM returns to IDLE.
REQ-038 Bench: shot_busy=1 at timer expiry for 50 cycles -> no SCAN until shot_busy falls, then SCAN next cycle.
REQ-039 Bench: the target dies in FIRE while ack is withheld -> fire_req drops, the FSM rescans the same column, and the next-higher alive row is selected.
REQ-040 Bench: reset or game_active=0 asserted in FIRE -> fire_req=0 on the next cycle; with FIRE_RANDOM_EN, the first column after reset = 8'hA5-derived value mod 13.
